// File: rtl/ptr_sync_gray.sv
// ptr_sync_gray
// -------------
// Brings a Gray-coded FIFO pointer from the remote clock domain into the
// local clk domain through an STAGES-deep flop chain. After the chain there
// is one history/decode stage that:
//   - registers the binary form of the pointer,
//   - pulses a change strobe,
//   - latches a sticky error when a synchronised step flips more than one
//     bit, which a legal Gray pointer never does.
// A saturating fill counter reports when the chain holds real samples
// instead of reset zeros.
//
// Ports
//   clk          in   local clock, rising edge
//   rst_n        in   asynchronous active-low reset (release synchronised outside)
//   ptr          in   [ADDRSIZE:0] Gray pointer from the remote domain
//   err_clr      in   synchronous clear of err_multibit
//   q_gray       out  [ADDRSIZE:0] synchronised Gray pointer (last sync stage)
//   q_bin        out  [ADDRSIZE:0] registered binary form of q_gray
//   ptr_chg      out  one-cycle pulse in the cycle q_bin first shows a new value
//   valid        out  sync pipeline filled since reset
//   err_multibit out  sticky multi-bit Gray transition flag
//
// Output qualification: there is no handshake. valid is a level qualifier.
// While valid=0, q_bin is not meaningful and ptr_chg is held at 0. Once
// valid is high it stays high until the next reset, and every cycle
// presents a fresh q_gray/q_bin/ptr_chg sample.
module ptr_sync_gray #(
    parameter int ADDRSIZE = 4,
    parameter int STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDRSIZE:0] ptr,
    input  logic              err_clr,
    output logic [ADDRSIZE:0] q_gray,
    output logic [ADDRSIZE:0] q_bin,
    output logic              ptr_chg,
    output logic              valid,
    output logic              err_multibit
);

    localparam int W  = ADDRSIZE + 1;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] FILL_MAX = CW'(STAGES + 1);

    // Fewer than two flops gives no metastability protection.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("ptr_sync_gray: STAGES must be >= 2");
        end
    endgenerate

    logic [W-1:0]  sync_q [STAGES];
    logic [W-1:0]  h;
    logic [W-1:0]  diff;
    logic          multi;
    logic [CW-1:0] fill_cnt;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain. Nothing is placed between stages so that the
    // synchronising flops can sit back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ptr;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_gray = sync_q[STAGES-1];

    // diff & (diff - 1) clears the lowest set bit. The result is non-zero
    // exactly when two or more bits changed.
    assign diff  = q_gray ^ h;
    assign multi = |(diff & (diff - W'(1)));

    // Counts edges since reset release and saturates. valid rises on the
    // (STAGES+1)th edge: STAGES edges to fill the chain plus one for the
    // decode stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (fill_cnt != FILL_MAX) begin
            fill_cnt <= fill_cnt + CW'(1);
        end
    end

    assign valid = (fill_cnt == FILL_MAX);

    // History/decode stage. The value of valid before the edge gates
    // ptr_chg and error detection. This hides the zero-to-first-sample
    // step that occurs while the chain fills after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h            <= '0;
            q_bin        <= '0;
            ptr_chg      <= 1'b0;
            err_multibit <= 1'b0;
        end else begin
            h       <= q_gray;
            q_bin   <= g2b(q_gray);
            ptr_chg <= valid && (diff != '0);
            // A new violation wins over a clear on the same edge.
            if (valid && multi) begin
                err_multibit <= 1'b1;
            end else if (err_clr) begin
                err_multibit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Bench for ptr_sync_gray.
// Main DUT (ADDRSIZE=4, STAGES=2): the driver records every pointer sample
// taken at a clock edge. From that history it derives the expected outputs
// for that edge and queues them. A monitor pops one entry per edge and
// compares it with the DUT outputs.
// Second DUT (ADDRSIZE=3, STAGES=3): directed latency and fill checks.
module tb_ptr_sync_gray;

    localparam int AW = 4;
    localparam int W  = AW + 1;
    localparam int S  = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- main DUT ----------------
    logic [W-1:0] ptr;
    logic         err_clr;
    logic [W-1:0] q_gray;
    logic [W-1:0] q_bin;
    logic         ptr_chg;
    logic         valid;
    logic         err_multibit;

    ptr_sync_gray #(.ADDRSIZE(AW), .STAGES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ptr          (ptr),
        .err_clr      (err_clr),
        .q_gray       (q_gray),
        .q_bin        (q_bin),
        .ptr_chg      (ptr_chg),
        .valid        (valid),
        .err_multibit (err_multibit)
    );

    // ---------------- second DUT (3 stages, 4-bit pointer) ----------------
    logic       rst3_n;
    logic [3:0] ptr3;
    logic       err_clr3;
    logic [3:0] q_gray3;
    logic [3:0] q_bin3;
    logic       ptr_chg3;
    logic       valid3;
    logic       err3;
    bit         done3;

    ptr_sync_gray #(.ADDRSIZE(3), .STAGES(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst3_n),
        .ptr          (ptr3),
        .err_clr      (err_clr3),
        .q_gray       (q_gray3),
        .q_bin        (q_bin3),
        .ptr_chg      (ptr_chg3),
        .valid        (valid3),
        .err_multibit (err3)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [12:0] exp_q[$];   // {valid, q_gray[4:0], q_bin[4:0], ptr_chg, err}
    int samp[$];             // pointer value sampled at edge 1, 2, ... since release
    bit err_m;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int gray(input int i);
        return i ^ (i >> 1);
    endfunction

    // Binary value whose Gray code is g, found by search.
    function automatic int g2b_m(input int g);
        for (int i = 0; i < (1 << W); i++) begin
            if (gray(i) == g) return i;
        end
        return 0;
    endfunction

    // Pointer sampled at edge j; 0 before release.
    function automatic int smp(input int j);
        if (j >= 1 && j <= samp.size()) return samp[j-1];
        return 0;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge. Drives inputs for the next rising edge e and
    // queues the outputs expected right after edge e:
    //   q_gray = sample(e-S+1)
    //   q_bin  = bin(sample(e-S))
    //   change/error from sample(e-S) vs sample(e-S-1), only once the
    //   pipeline was already full before edge e.
    task automatic step(input int p, input bit clr);
        int  e;
        int  a;
        int  b0;
        bit  v;
        bit  vp;
        logic [12:0] x;
        ptr     = p[W-1:0];
        err_clr = clr;
        samp.push_back(p);
        e  = samp.size();
        v  = (e >= S + 1);
        vp = (e - 1 >= S + 1);
        a  = smp(e - S);
        b0 = smp(e - S - 1);
        if (vp && ($countones(a ^ b0) > 1)) err_m = 1'b1;
        else if (clr) err_m = 1'b0;
        x = {v, 5'(smp(e - S + 1)), 5'(g2b_m(a)), vp && (a != b0), err_m};
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    logic [12:0] mx;
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mx = exp_q.pop_front();
            chk("valid",        int'(valid),        int'(mx[12]));
            chk("q_gray",       int'(q_gray),       int'(mx[11:7]));
            chk("q_bin",        int'(q_bin),        int'(mx[6:2]));
            chk("ptr_chg",      int'(ptr_chg),      int'(mx[1]));
            chk("err_multibit", int'(err_multibit), int'(mx[0]));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   int'(valid),        0);
        chk({tag, "_q_gray"},  int'(q_gray),       0);
        chk({tag, "_q_bin"},   int'(q_bin),        0);
        chk({tag, "_ptr_chg"}, int'(ptr_chg),      0);
        chk({tag, "_err"},     int'(err_multibit), 0);
    endtask

    // ---------------- second DUT directed sequence ----------------
    initial begin
        rst3_n   = 1'b0;
        ptr3     = 4'h0;
        err_clr3 = 1'b0;
        done3    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 3) chk("s3_valid_edge3", int'(valid3), 0);
            if (n == 4) chk("s3_valid_edge4", int'(valid3), 1);
            if (n == 7) chk("s3_q_gray_k+1", int'(q_gray3), 0);
            if (n == 8) begin
                chk("s3_q_gray_k+2", int'(q_gray3), 1);
                chk("s3_q_bin_k+2",  int'(q_bin3),  0);
            end
            if (n == 9) begin
                chk("s3_q_bin_k+3",   int'(q_bin3),   1);
                chk("s3_ptr_chg_k+3", int'(ptr_chg3), 1);
            end
            if (n == 10) begin
                chk("s3_ptr_chg_k+4", int'(ptr_chg3), 0);
                chk("s3_err",         int'(err3),     0);
            end
            if (n == 5) begin
                @(negedge clk);
                ptr3 = 4'h1;   // sampled at edge 6
            end
        end
        done3 = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int b;
        int r;
        rst_n   = 1'b0;
        ptr     = 5'h10;
        err_clr = 1'b0;
        err_m   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // Fill with a constant 5'h10, then hold.
        for (int i = 0; i < 5; i++) step(5'h10, 1'b0);

        // Single step 0 -> 1.
        for (int i = 0; i < 4; i++) step(0, 1'b0);
        for (int i = 0; i < 4; i++) step(1, 1'b0);

        // Full Gray sweep, including the 31 -> 0 wrap.
        for (int i = 0; i < 32; i++) step(gray(i), 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b0);

        // Multi-bit error, hold, clear, and set on the same edge as a clear.
        for (int i = 0; i < 3; i++) step(5'b00000, 1'b0);
        for (int i = 0; i < 4; i++) step(5'b00011, 1'b0);
        step(5'b00011, 1'b1);
        for (int i = 0; i < 3; i++) step(5'b00011, 1'b0);
        step(5'b01100, 1'b0);            // flagged two edges later
        step(5'b01100, 1'b0);
        step(5'b01100, 1'b1);            // clear on the violation edge
        for (int i = 0; i < 3; i++) step(5'b01100, 1'b0);

        // Randomised walk: mostly legal Gray steps, some holds, rare jumps.
        b = g2b_m(5'b01100);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) b = (b + 1) % 32;
            else if (r == 8) b = (b + 31) % 32;
            else if (r == 9) b = $urandom_range(0, 31);
            step(gray(b), $urandom_range(0, 7) == 0);
        end

        // Async reset in the middle of a sweep.
        for (int i = 0; i < 16; i++) step(gray(i), 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        chk("midreset_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        samp.delete();
        err_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Multi-bit value during refill must not raise the error.
        for (int i = 0; i < 6; i++) step(5'h1B, 1'b0);
        b = g2b_m(5'h1B);
        for (int i = 0; i < 20; i++) begin
            b = (b + 1) % 32;
            step(gray(b), 1'b0);
        end

        @(posedge clk);
        #2;
        chk("final_queue_empty", exp_q.size(), 0);
        chk("dut3_done", int'(done3), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ptr_sync_gray.md
Name: ptr_sync_gray

Overview:
- Parametrised N-stage synchroniser for Gray-coded FIFO pointers crossing into the local clock domain.
- Adds three things to the plain two-flop pointer sync:
  - configurable stage count
  - registered Gray-to-binary output
  - a change strobe, a pipeline-fill valid flag, and a sticky error flag for illegal multi-bit Gray transitions.
- Sits in the async FIFO between the remote pointer register and local full/empty logic.

Parameters:
- ADDRSIZE, 4: FIFO address bits. Pointer width is ADDRSIZE+1, which includes the wrap bit.
- STAGES, 2: number of synchroniser flops. Must be >= 2; a lower value is an elaboration error.

Ports:
- clk  in  1  local domain clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ptr  in  ADDRSIZE+1  Gray-coded pointer from the remote domain (asynchronous to clk).
- err_clr  in  1  synchronous clear of err_multibit.
- q_gray  out  ADDRSIZE+1  synchronised Gray pointer (last stage).
- q_bin  out  ADDRSIZE+1  binary equivalent of q_gray, registered.
- ptr_chg  out  1  one-cycle pulse when q_bin takes a new value.
- valid  out  1  synchroniser pipeline filled since reset.
- err_multibit  out  1  sticky: a synchronised transition changed more than one bit.

Behaviour:
- Reset:
  - rst_n low clears all of the following immediately, independent of clk: every sync stage, the history register h, q_gray, q_bin, ptr_chg, valid, err_multibit, and the fill counter.
  - Reset release is assumed synchronised externally.
- Sync chain:
  - s[0] <= ptr; s[i] <= s[i-1]; q_gray = s[STAGES-1].
  - A ptr value stable before edge k appears on q_gray after edge k+STAGES-1, i.e. STAGES edges of latency.
  - No logic between stages.
- History/decode stage, every edge:
  - h <= q_gray
  - q_bin <= g2b(q_gray), where b[MSB]=g[MSB] and b[i]=b[i+1]^g[i]
  - ptr_chg <= (q_gray != h)
  - q_bin therefore lags q_gray by 1 cycle; total latency from ptr is STAGES+1.
  - ptr_chg is high in exactly the cycle q_bin first shows the new value. A pointer changing every cycle holds ptr_chg high continuously.
- Error detect:
  - On an edge where popcount(q_gray ^ h) > 1, err_multibit <= 1.
  - err_clr=1 clears it on the next edge.
  - Set has priority over clear when both occur on the same edge.
  - Error detection is suppressed while valid=0, so the reset-fill transient never flags.
- Valid:
  - A saturating counter of width clog2(STAGES+2) increments each edge after reset.
  - valid goes high on the (STAGES+1)th edge after release and stays high until the next reset.
  - q_bin and ptr_chg are meaningful only when valid=1. ptr_chg is forced to 0 while valid=0.
- Wrap-around:
  - Gray wrap from 2^(ADDRSIZE+1)-1 to 0 is a one-bit change. It raises no error; ptr_chg pulses and q_bin returns to 0.
- Holding ptr constant: ptr_chg=0, and q_gray, q_bin and h stay static.
- Reset mid-operation: all state, including valid and err_multibit, returns to 0 at once; the fill counter restarts on release.

Test Plan:
1. Reset/fill (STAGES=2): hold rst_n=0, ptr=5'h10 -> all outputs 0. Release -> valid=1 after the 3rd edge, q_gray=5'h10, q_bin=5'h1F, err_multibit=0.
2. Latency: ptr steps 5'b00000 -> 5'b00001, stable from edge k -> q_gray=1 after edge k+1, q_bin=1 and ptr_chg=1 after edge k+2, ptr_chg back to 0 after edge k+3.
3. Full Gray sweep: ptr cycles Gray(0..31) then Gray(0), one per cycle -> q_bin traces 0..31,0 with a 3-cycle lag, ptr_chg held 1, err_multibit stays 0 across the 31->0 wrap.
4. Multi-bit error:
   - ptr 5'b00000 -> 5'b00011 -> err_multibit=1 in the same cycle as ptr_chg, and it holds.
   - err_clr pulse -> 0 next edge.
   - err_clr asserted on the same edge as a new violation (5'b00011 -> 5'b01100) -> stays 1.
5. STAGES=3, ADDRSIZE=3: step 4'b0000 -> 4'b0001 -> q_gray after 3 edges, q_bin after 4, valid after the 4th edge post-reset.
6. Async reset mid-sweep: drop rst_n between edges -> all outputs 0 before the next edge. Release -> valid re-asserts after STAGES+1 edges; err_multibit does not set during refill.
